// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the requester arbiter in front of mem_ctrl.
package mem_arb_pkg;

  localparam int unsigned NUM_MST    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned MAX_OUTST  = 4;
  localparam int unsigned ID_W       = $clog2(NUM_MST);
  localparam int unsigned BE_W       = DATA_WIDTH / 8;

  typedef logic [ID_W-1:0]    mst_id_t;
  typedef logic [NUM_MST-1:0] mst_vec_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
    logic                  wen;
  } mem_req_t;

  // One-hot pick of the first request at or above ptr, wrapping around.
  function automatic mst_vec_t rr_pick(input mst_vec_t req, input mst_id_t ptr);
    mst_vec_t gnt;
    logic     found;
    mst_id_t  idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      idx = mst_id_t'((32'(ptr) + i) % NUM_MST);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic mst_id_t oh2id(input mst_vec_t oh);
    mst_id_t id;
    id = '0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      if (oh[i]) id = id | mst_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// Small synchronous FIFO holding the requester ID of each outstanding read.
module mem_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // Status only depends on registered state, so callers may feed it back into push/pop.
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only alongside a real pop.
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of NUM_MST requesters onto the mem_ctrl slave port, with
// in-order read-response routing through an ID FIFO.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_MST    = mem_arb_pkg::NUM_MST,
  parameter int unsigned DATA_WIDTH = mem_arb_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH,
  parameter int unsigned MAX_OUTST  = mem_arb_pkg::MAX_OUTST,
  parameter int unsigned BE_W       = DATA_WIDTH / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MST-1:0]           m_req_i,
  output logic [NUM_MST-1:0]           m_gnt_o,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MST*DATA_WIDTH-1:0] m_data_i,
  input  logic [NUM_MST*BE_W-1:0]      m_be_i,
  input  logic [NUM_MST-1:0]           m_wen_i,
  output logic [DATA_WIDTH-1:0]        m_r_data_o,
  output logic [NUM_MST-1:0]           m_r_valid_o,
  input  logic [NUM_MST-1:0]           m_r_ready_i,
  output logic                         s_req_o,
  input  logic                         s_gnt_i,
  output logic [ADDR_WIDTH-1:0]        s_addr_o,
  output logic [DATA_WIDTH-1:0]        s_data_o,
  output logic [BE_W-1:0]              s_be_o,
  output logic                         s_wen_o,
  input  logic [DATA_WIDTH-1:0]        s_r_data_i,
  input  logic                         s_r_valid_i,
  output logic                         s_r_ready_o,
  output logic                         err_o
);

  mem_req_t req_pl [NUM_MST];
  mem_req_t win;
  mst_vec_t elig, win_oh;
  mst_id_t  win_id, head_id;
  mst_id_t  rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
  logic     lock_q, lock_d, err_q, err_d;
  logic     fifo_full, fifo_empty, fifo_push, fifo_pop, rd_ok, hs;

  mem_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (win_id),
    .pop_i   (fifo_pop),
    .head_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Response routing; with nothing outstanding a stray response is swallowed.
  always_comb begin
    s_r_ready_o = fifo_empty ? 1'b1 : m_r_ready_i[head_id];
    fifo_pop    = s_r_valid_i & s_r_ready_o & ~fifo_empty;
    m_r_data_o  = s_r_data_i;
    m_r_valid_o = '0;
    if (!rst_i && s_r_valid_i && !fifo_empty) m_r_valid_o[head_id] = 1'b1;
  end

  // Request arbitration; a stalled winner stays locked until its handshake.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      req_pl[i].addr = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      req_pl[i].data = m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      req_pl[i].be   = m_be_i[i*BE_W +: BE_W];
      req_pl[i].wen  = m_wen_i[i];
    end
    rd_ok     = ~fifo_full | fifo_pop;
    elig      = m_req_i & (m_wen_i | {NUM_MST{rd_ok}});
    win_oh    = lock_q ? (elig & (mst_vec_t'(1) << lock_id_q)) : rr_pick(elig, rr_ptr_q);
    win_id    = oh2id(win_oh);
    win       = req_pl[win_id];
    s_req_o   = ~rst_i & (|win_oh);
    s_addr_o  = win.addr;
    s_data_o  = win.data;
    s_be_o    = win.be;
    s_wen_o   = win.wen;
    hs        = s_req_o & s_gnt_i;
    m_gnt_o   = hs ? win_oh : '0;
    fifo_push = hs & ~win.wen;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (s_r_valid_i & fifo_empty) | (s_gnt_i & ~s_req_o);
    if (hs) begin
      rr_ptr_d = (32'(win_id) == NUM_MST - 1) ? '0 : win_id + mst_id_t'(1);
      lock_d   = 1'b0;
    end else if (s_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = win_id;
    end else begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: requester driver, downstream stub, grant/response monitor.
module tb_mem_req_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_req, m_gnt_o, m_wen, m_r_valid_o, m_r_ready;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_data;
  logic [NM*BW-1:0] m_be;
  logic [DW-1:0]    m_r_data_o, s_data_o, s_r_data;
  logic [AW-1:0]    s_addr_o;
  logic [BW-1:0]    s_be_o;
  logic             s_req_o, s_gnt_i, s_wen_o, s_r_valid, s_r_ready_o, err_o;
  logic             gnt_en, gnt_force;

  always #5 clk = ~clk;

  // Downstream stub: accepts whatever is offered when enabled, or forces a stray grant.
  assign s_gnt_i = (gnt_en & s_req_o) | gnt_force;

  mem_req_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_req_i     (m_req),
    .m_gnt_o     (m_gnt_o),
    .m_addr_i    (m_addr),
    .m_data_i    (m_data),
    .m_be_i      (m_be),
    .m_wen_i     (m_wen),
    .m_r_data_o  (m_r_data_o),
    .m_r_valid_o (m_r_valid_o),
    .m_r_ready_i (m_r_ready),
    .s_req_o     (s_req_o),
    .s_gnt_i     (s_gnt_i),
    .s_addr_o    (s_addr_o),
    .s_data_o    (s_data_o),
    .s_be_o      (s_be_o),
    .s_wen_o     (s_wen_o),
    .s_r_data_i  (s_r_data),
    .s_r_valid_i (s_r_valid),
    .s_r_ready_o (s_r_ready_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } op_t;

  typedef struct packed {
    logic [1:0]  id;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } gnt_exp_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_exp_t;

  op_t      op_q [NM][$];
  gnt_exp_t exp_gnt [$];
  rsp_exp_t exp_rsp [$];
  int       n_chk = 0;
  int       n_fail = 0;
  int       gnt_cnt = 0;
  logic [NM-1:0] gnt_seen = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_gnt(input int m, input logic wen, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    exp_gnt.push_back('{id: 2'(m), wen: wen, addr: addr, data: data, be: be});
  endtask

  task automatic issue(input int m, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input bit with_exp);
    op_q[m].push_back('{wen: wen, addr: addr, data: data, be: be});
    if (with_exp) expect_gnt(m, wen, addr, data, be);
  endtask

  function automatic bit busy();
    bit b = (exp_gnt.size() != 0);
    for (int i = 0; i < NM; i++) if (op_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy() && c < budget) begin
      tick();
      c++;
    end
    n_chk++;
    if (busy()) begin
      n_fail++;
      $display("FAIL wait_idle: requests still pending after %0d cycles", budget);
    end
  endtask

  task automatic send_resp(input logic [31:0] d);
    int   c  = 0;
    logic hs = 1'b0;
    s_r_valid = 1'b1;
    s_r_data  = d;
    while (!hs && c < 20) begin
      @(negedge clk);
      hs = s_r_ready_o;
      tick();
      c++;
    end
    s_r_valid = 1'b0;
    n_chk++;
    if (!hs) begin
      n_fail++;
      $display("FAIL resp_accept: data 0x%0h never accepted, s_r_ready_o stayed 0", d);
    end
  endtask

  // Requester driver: present the head op of each master, retire it once granted.
  initial begin
    m_req = '0; m_wen = '0; m_addr = '0; m_data = '0; m_be = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NM; i++) begin
        if (gnt_seen[i] && op_q[i].size() != 0) void'(op_q[i].pop_front());
        if (op_q[i].size() != 0) begin
          m_req[i]            = 1'b1;
          m_wen[i]            = op_q[i][0].wen;
          m_addr[i*AW +: AW]  = op_q[i][0].addr;
          m_data[i*DW +: DW]  = op_q[i][0].data;
          m_be[i*BW +: BW]    = op_q[i][0].be;
        end else begin
          m_req[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every grant and every completed response is matched against the scoreboard.
  initial begin
    gnt_exp_t ge;
    rsp_exp_t re;
    forever begin
      @(negedge clk);
      gnt_seen = m_gnt_o;
      if (!rst && m_gnt_o != '0) begin
        gnt_cnt++;
        if (exp_gnt.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_grant: m_gnt_o=%b, no grant expected", m_gnt_o);
        end else begin
          ge = exp_gnt.pop_front();
          check("grant_master", 64'(m_gnt_o), 64'(4'(1) << ge.id));
          check("grant_addr", 64'(s_addr_o), 64'(ge.addr));
          check("grant_wen", 64'(s_wen_o), 64'(ge.wen));
          check("grant_be", 64'(s_be_o), 64'(ge.be));
          if (ge.wen) check("grant_wdata", 64'(s_data_o), 64'(ge.data));
        end
      end
      if ((m_r_valid_o & m_r_ready) != '0) begin
        if (exp_rsp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_resp: m_r_valid_o=%b, no response expected", m_r_valid_o);
        end else begin
          re = exp_rsp.pop_front();
          check("resp_route", 64'(m_r_valid_o), 64'(4'(1) << re.id));
          check("resp_data", 64'(m_r_data_o), 64'(re.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int c;
    rst = 1'b1; gnt_en = 1'b1; gnt_force = 1'b0;
    s_r_valid = 1'b0; s_r_data = '0; m_r_ready = '1;
    tick();

    // Single master write then read, issued while still in reset
    issue(0, 1'b1, 32'h10, 32'h1234, 4'hF, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    s_r_valid = 1'b1;
    tick();
    @(negedge clk);
    check("rst_s_req", 64'(s_req_o), 64'd0);
    check("rst_m_gnt", 64'(m_gnt_o), 64'd0);
    check("rst_r_valid", 64'(m_r_valid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    tick();
    s_r_valid = 1'b0;
    rst = 1'b0;
    wait_idle(20);
    exp_rsp.push_back('{id: 2'd0, data: 32'h1234});
    send_resp(32'h1234);
    @(negedge clk);
    check("t1_err", 64'(err_o), 64'd0);

    // Four masters writing back to back from rr_ptr=0
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(0, 1'b1, 32'h100, 32'hA0, 4'hF, 1'b0);
    issue(0, 1'b1, 32'h104, 32'hA1, 4'h3, 1'b0);
    issue(1, 1'b1, 32'h110, 32'hB0, 4'hC, 1'b0);
    issue(2, 1'b1, 32'h120, 32'hC0, 4'h1, 1'b0);
    issue(3, 1'b1, 32'h130, 32'hD0, 4'h8, 1'b0);
    expect_gnt(0, 1'b1, 32'h100, 32'hA0, 4'hF);
    expect_gnt(1, 1'b1, 32'h110, 32'hB0, 4'hC);
    expect_gnt(2, 1'b1, 32'h120, 32'hC0, 4'h1);
    expect_gnt(3, 1'b1, 32'h130, 32'hD0, 4'h8);
    expect_gnt(0, 1'b1, 32'h104, 32'hA1, 4'h3);
    g0 = gnt_cnt;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #1;
    check("t2_b2b_grants", 64'(gnt_cnt - g0), 64'd5);
    wait_idle(10);

    // Lock: master 2 stalls, master 1 joins later, 2 must still win first
    gnt_en = 1'b0;
    issue(2, 1'b1, 32'h200, 32'hE0, 4'hF, 1'b1);
    tick();
    @(negedge clk);
    check("t3_s_req", 64'(s_req_o), 64'd1);
    check("t3_addr_c0", 64'(s_addr_o), 64'h200);
    check("t3_no_gnt", 64'(m_gnt_o), 64'd0);
    tick();
    issue(1, 1'b1, 32'h100, 32'hF0, 4'hF, 1'b1);
    @(negedge clk);
    check("t3_addr_c1", 64'(s_addr_o), 64'h200);
    tick();
    @(negedge clk);
    check("t3_addr_c2", 64'(s_addr_o), 64'h200);
    tick();
    gnt_en = 1'b1;
    wait_idle(10);

    // FIFO full holds off the fifth read until a response pops
    for (int k = 0; k < 5; k++) issue(3, 1'b0, 32'h300 + 32'(4*k), 32'h0, 4'hF, 1'b1);
    g0 = gnt_cnt;
    c  = 0;
    while (gnt_cnt - g0 < 4 && c < 30) begin
      tick();
      c++;
    end
    repeat (3) tick();
    @(negedge clk);
    check("t4_granted_4", 64'(gnt_cnt - g0), 64'd4);
    check("t4_full_hold", 64'(s_req_o), 64'd0);
    tick();
    exp_rsp.push_back('{id: 2'd3, data: 32'h3000});
    s_r_valid = 1'b1;
    s_r_data  = 32'h3000;
    @(negedge clk);
    check("t4_pop_gnt", 64'(m_gnt_o), 64'h8);
    check("t4_pop_ready", 64'(s_r_ready_o), 64'd1);
    tick();
    s_r_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      exp_rsp.push_back('{id: 2'd3, data: 32'h3000 + 32'(k)});
      send_resp(32'h3000 + 32'(k));
    end
    wait_idle(10);

    // Interleaved reads 1,0,2 with master 0 stalling its response
    issue(1, 1'b0, 32'h410, 32'h0, 4'hF, 1'b1);
    tick();
    issue(0, 1'b0, 32'h400, 32'h0, 4'hF, 1'b1);
    tick();
    issue(2, 1'b0, 32'h420, 32'h0, 4'hF, 1'b1);
    wait_idle(20);
    exp_rsp.push_back('{id: 2'd1, data: 32'h5001});
    exp_rsp.push_back('{id: 2'd0, data: 32'h5000});
    exp_rsp.push_back('{id: 2'd2, data: 32'h5002});
    m_r_ready[0] = 1'b0;
    send_resp(32'h5001);
    s_r_valid = 1'b1;
    s_r_data  = 32'h5000;
    repeat (2) begin
      @(negedge clk);
      check("t5_stall_ready", 64'(s_r_ready_o), 64'd0);
      check("t5_stall_valid", 64'(m_r_valid_o), 64'h1);
      tick();
    end
    m_r_ready[0] = 1'b1;
    @(negedge clk);
    check("t5_release_ready", 64'(s_r_ready_o), 64'd1);
    tick();
    s_r_valid = 1'b0;
    send_resp(32'h5002);

    // Stray response: dropped, sticky error, cleared by reset
    @(negedge clk);
    check("t6_err_before", 64'(err_o), 64'd0);
    tick();
    s_r_valid = 1'b1;
    s_r_data  = 32'hDEAD;
    @(negedge clk);
    check("t6_drop_ready", 64'(s_r_ready_o), 64'd1);
    check("t6_drop_valid", 64'(m_r_valid_o), 64'd0);
    tick();
    s_r_valid = 1'b0;
    @(negedge clk);
    check("t6_err_set", 64'(err_o), 64'd1);
    tick();
    tick();
    @(negedge clk);
    check("t6_err_sticky", 64'(err_o), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_r_ready = '0;
    @(negedge clk);
    check("t6_err_cleared", 64'(err_o), 64'd0);
    check("t6_fifo_empty", 64'(s_r_ready_o), 64'd1);
    tick();
    m_r_ready = '1;
    issue(3, 1'b1, 32'h630, 32'h63, 4'hF, 1'b0);
    issue(2, 1'b1, 32'h620, 32'h62, 4'hF, 1'b0);
    issue(1, 1'b1, 32'h610, 32'h61, 4'hF, 1'b0);
    issue(0, 1'b1, 32'h600, 32'h60, 4'hF, 1'b0);
    expect_gnt(0, 1'b1, 32'h600, 32'h60, 4'hF);
    expect_gnt(1, 1'b1, 32'h610, 32'h61, 4'hF);
    expect_gnt(2, 1'b1, 32'h620, 32'h62, 4'hF);
    expect_gnt(3, 1'b1, 32'h630, 32'h63, 4'hF);
    wait_idle(20);

    // Grant with no request, then reset dropping an outstanding read
    gnt_force = 1'b1;
    tick();
    gnt_force = 1'b0;
    @(negedge clk);
    check("t7_stray_gnt_err", 64'(err_o), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b1);
    wait_idle(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t7_err_after_rst", 64'(err_o), 64'd0);
    tick();
    s_r_valid = 1'b1;
    s_r_data  = 32'h77;
    @(negedge clk);
    check("t7_dropped_id", 64'(m_r_valid_o), 64'd0);
    tick();
    s_r_valid = 1'b0;
    @(negedge clk);
    check("t7_inflight_err", 64'(err_o), 64'd1);

    check("exp_gnt_drained", 64'(exp_gnt.size()), 64'd0);
    check("exp_rsp_drained", 64'(exp_rsp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
